// File: rtl/cnt_sched_if.sv
// cnt_sched_if: requester handshake and counter datapath signals of the shared-counter scheduler
interface cnt_sched_if #(parameter int WIDTH = 8);
  logic req0, req1;
  logic [WIDTH-1:0] start0, stop0, start1, stop1;
  logic [WIDTH-1:0] cnt, data;
  logic load, ena, gnt0, gnt1, done0, done1, busy;
  modport master (
    output req0, req1, start0, stop0, start1, stop1, cnt,
    input data, load, ena, gnt0, gnt1, done0, done1, busy
  );
  modport slave (
    input req0, req1, start0, stop0, start1, stop1, cnt,
    output data, load, ena, gnt0, gnt1, done0, done1, busy
  );
endinterface

// File: rtl/cnt_sched.sv
// cnt_sched: round-robin scheduler granting one of two requesters a shared loadable up-counter
module cnt_sched #(parameter int WIDTH = 8) (
  input logic clk,
  input logic rst,
  cnt_sched_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LDC, RUN, FIN} state_t;
  state_t state, state_n;
  logic owner, owner_n, last, last_n, own_req, hit, pick;
  logic [WIDTH-1:0] start_q, stop_q, start_n, stop_n;
  assign own_req = owner ? bus.req1 : bus.req0;
  assign hit = bus.cnt == stop_q;
  assign pick = (bus.req0 && bus.req1) ? ~last : bus.req1;
  always_comb begin
    state_n = state;
    owner_n = owner;
    last_n = last;
    start_n = start_q;
    stop_n = stop_q;
    case (state)
      IDLE: if (bus.req0 || bus.req1) begin
        state_n = LDC;
        owner_n = pick;
        start_n = pick ? bus.start1 : bus.start0;
        stop_n = pick ? bus.stop1 : bus.stop0;
      end
      LDC: begin
        state_n = own_req ? RUN : IDLE;
        last_n = own_req ? last : owner;
      end
      RUN: begin
        state_n = !own_req ? IDLE : hit ? FIN : RUN;
        last_n = own_req ? last : owner;
      end
      FIN: begin
        state_n = IDLE;
        last_n = owner;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner <= 1'b0;
      last <= 1'b1;
      start_q <= '0;
      stop_q <= '0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      last <= last_n;
      start_q <= start_n;
      stop_q <= stop_n;
    end
  end
  // the RUN-state compare is combinational so the counter stops exactly on stop_q
  assign bus.busy = state != IDLE;
  assign bus.gnt0 = bus.busy && !owner;
  assign bus.gnt1 = bus.busy && owner;
  assign bus.load = state == LDC;
  assign bus.ena = state == LDC || (state == RUN && !hit);
  assign bus.done0 = state == FIN && !owner;
  assign bus.done1 = state == FIN && owner;
  assign bus.data = start_q;
endmodule

// File: tb/tb_cnt_sched.sv
// tb_cnt_sched: randomized and directed checks of cnt_sched against a job-timeline reference model
module tb_cnt_sched;
  logic clk = 0, rst = 1;
  logic req [2];
  logic [7:0] st [2], sp [2];
  logic [7:0] cnt = 0;
  int errs = 0, checks = 0;
  int nd [2];
  int order [$];
  bit m_act = 0, m_own = 0, m_last = 1;
  int m_age = 0, m_n = 0;
  logic [7:0] m_start = 0;
  cnt_sched_if #(.WIDTH(8)) bus ();
  cnt_sched #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  assign bus.req0 = req[0];
  assign bus.req1 = req[1];
  assign bus.start0 = st[0];
  assign bus.stop0 = sp[0];
  assign bus.start1 = st[1];
  assign bus.stop1 = sp[1];
  assign bus.cnt = cnt;
  always #5 clk = ~clk;
  // the external counter the scheduler drives
  always @(posedge clk) if (bus.load) cnt <= bus.data; else if (bus.ena) cnt <= cnt + 8'd1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // a job of n increments spans ages 0 (load), 1..n+1 (run), n+2 (done)
  task automatic model_edge();
    logic [7:0] d;
    bit o;
    if (rst) begin
      m_act = 0;
      m_last = 1;
    end else if (m_act) begin
      if ((m_age <= m_n + 1 && !req[m_own]) || m_age == m_n + 2) begin
        m_act = 0;
        m_last = m_own;
      end else m_age++;
    end else if (req[0] || req[1]) begin
      o = (req[0] && req[1]) ? !m_last : req[1];
      m_own = o;
      m_start = st[o];
      d = sp[o] - st[o];
      m_n = int'(d);
      m_age = 0;
      m_act = 1;
    end
  endtask

  task automatic check_cycle();
    logic [7:0] ec;
    chk("busy", bus.busy, m_act);
    chk("gnt0", bus.gnt0, m_act && !m_own);
    chk("gnt1", bus.gnt1, m_act && m_own);
    chk("gnt_excl", bus.gnt0 & bus.gnt1, 0);
    chk("load", bus.load, m_act && m_age == 0);
    chk("ena", bus.ena, m_act && m_age <= m_n);
    chk("done0", bus.done0, m_act && !m_own && m_age == m_n + 2);
    chk("done1", bus.done1, m_act && m_own && m_age == m_n + 2);
    if (m_act && m_age == 0) chk("data", bus.data, m_start);
    if (m_act && m_age >= 1) begin
      ec = m_start + 8'((m_age - 1 < m_n) ? m_age - 1 : m_n);
      chk("cnt", cnt, ec);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_cycle();
  endtask

  task automatic serve(input int max);
    int k = 0;
    while ((req[0] || req[1] || bus.busy) && k < max) begin
      cyc();
      if (bus.done0) begin req[0] = 0; nd[0]++; end
      if (bus.done1) begin req[1] = 0; nd[1]++; end
      k++;
    end
    chk("serve_timeout", req[0] || req[1] || bus.busy, 0);
  endtask

  task automatic wait_cnt(input logic [7:0] v, input int max);
    int k = 0;
    while (cnt != v && k < max) begin cyc(); k++; end
    chk("wait_cnt", cnt, v);
  endtask

  initial begin
    bit pg0, pg1;
    req[0] = 0; req[1] = 0;
    st[0] = 0; st[1] = 0; sp[0] = 0; sp[1] = 0;
    @(negedge clk);
    cyc();
    cyc();
    chk("rst_data", bus.data, 0);
    rst = 0;
    nd[0] = 0; nd[1] = 0;
    req[0] = 1; st[0] = 5; sp[0] = 9;
    serve(30);
    chk("job0_done", nd[0], 1);
    chk("job0_cnt", cnt, 9);
    nd[1] = 0;
    req[1] = 1; st[1] = 250; sp[1] = 3;
    serve(30);
    chk("wrap_done", nd[1], 1);
    chk("wrap_cnt", cnt, 3);
    rst = 1;
    req[0] = 1; req[1] = 1; st[0] = 0; sp[0] = 2; st[1] = 0; sp[1] = 2;
    cyc();
    rst = 0;
    pg0 = 0; pg1 = 0;
    for (int c = 0; c < 18; c++) begin
      cyc();
      if (bus.gnt0 && !pg0) order.push_back(0);
      if (bus.gnt1 && !pg1) order.push_back(1);
      pg0 = bus.gnt0; pg1 = bus.gnt1;
    end
    chk("arb_count", order.size() >= 3, 1);
    if (order.size() >= 3) begin
      chk("arb_first", order[0], 0);
      chk("arb_second", order[1], 1);
      chk("arb_third", order[2], 0);
    end
    req[0] = 0; req[1] = 0;
    serve(20);
    nd[0] = 0;
    req[0] = 1; st[0] = 10; sp[0] = 10;
    serve(20);
    chk("eq_done", nd[0], 1);
    chk("eq_cnt", cnt, 10);
    nd[0] = 0;
    req[0] = 1; st[0] = 0; sp[0] = 100;
    wait_cnt(20, 40);
    req[0] = 0;
    cyc();
    chk("abort_cnt", cnt == 20 || cnt == 21, 1);
    chk("abort_busy", bus.busy, 0);
    chk("abort_nodone", nd[0], 0);
    req[0] = 1; req[1] = 1; st[0] = 0; sp[0] = 1; st[1] = 0; sp[1] = 1;
    cyc();
    chk("abort_rr", bus.gnt1, 1);
    serve(40);
    req[0] = 1; st[0] = 0; sp[0] = 100;
    wait_cnt(50, 80);
    rst = 1; req[0] = 0;
    cyc();
    rst = 0;
    chk("midrst_data", bus.data, 0);
    chk("midrst_busy", bus.busy, 0);
    nd[0] = 0;
    req[0] = 1; st[0] = 3; sp[0] = 7;
    serve(30);
    chk("fresh_done", nd[0], 1);
    chk("fresh_cnt", cnt, 7);
    for (int c = 0; c < 4000; c++) begin
      rst = $urandom_range(0, 399) == 0;
      for (int i = 0; i < 2; i++) begin
        if (req[i] && (i == 0 ? bus.done0 : bus.done1)) req[i] = 0;
        else if (req[i] && $urandom_range(0, 59) == 0) req[i] = 0;
        else if (!req[i] && $urandom_range(0, 2) == 0) begin
          req[i] = 1;
          st[i] = 8'($urandom);
          sp[i] = $urandom_range(0, 3) == 0 ? 8'($urandom) : st[i] + 8'($urandom_range(0, 12));
        end else if (req[i] && $urandom_range(0, 7) == 0) begin
          st[i] = 8'($urandom);
          sp[i] = st[i] + 8'($urandom_range(0, 12));
        end
      end
      cyc();
    end
    rst = 0; req[0] = 0; req[1] = 0;
    serve(300);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/cnt_sched.md
Name: cnt_sched

Overview:
- Two-requester round-robin scheduler that shares one 8-bit loadable up-counter (ports CNT, DATA, LOAD, ENA).
- A granted requester supplies a start value and a stop value.
- The scheduler loads the counter with the start value, enables counting until CNT equals the stop value, then reports completion.
- Sits between requesting control logic and the counter datapath; it is the only driver of the counter's DATA/LOAD/ENA.

Parameters:
- WIDTH, 8, width of counter value, START/STOP and DATA buses.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RST  input  1  synchronous, active-high reset.
- REQ0  input  1  requester 0 request; must be held until DONE0 or it aborts.
- REQ1  input  1  requester 1 request; same rules as REQ0.
- START0  input  WIDTH  requester 0 load value; sampled at grant.
- STOP0  input  WIDTH  requester 0 terminal value; sampled at grant.
- START1  input  WIDTH  requester 1 load value; sampled at grant.
- STOP1  input  WIDTH  requester 1 terminal value; sampled at grant.
- CNT  input  WIDTH  current counter value, fed back from the counter.
- DATA  output  WIDTH  parallel-load value to the counter.
- LOAD  output  1  counter parallel-load strobe.
- ENA  output  1  counter enable.
- GNT0  output  1  requester 0 owns the counter.
- GNT1  output  1  requester 1 owns the counter.
- DONE0  output  1  one-cycle pulse: requester 0 job complete.
- DONE1  output  1  one-cycle pulse: requester 1 job complete.
- BUSY  output  1  high in any state other than IDLE.

Behaviour:
- Registers:
  - state: IDLE, LDC, RUN, FIN.
  - owner (1 bit).
  - start_q, stop_q (WIDTH each).
  - last (round-robin pointer: last-served requester).
- Reset (RST=1 at an edge):
  - state=IDLE, last=1 (so requester 0 wins the first tie), start_q=stop_q=0.
  - All outputs 0: DATA=0, LOAD=0, ENA=0, GNT0/1=0, DONE0/1=0, BUSY=0.
  - Reset overrides every other input, including mid-job; a job interrupted by reset produces no DONE pulse.
- IDLE:
  - No REQ: stay in IDLE.
  - Exactly one REQ: grant that requester.
  - Both REQ: grant the requester != last.
  - On grant: capture owner, start_q=STARTx, stop_q=STOPx; go to LDC.
- LDC (exactly 1 cycle):
  - DATA=start_q, LOAD=1, ENA=1, GNTowner=1.
  - Next state: RUN.
- RUN:
  - LOAD=0, DATA=start_q.
  - ENA=1 when CNT!=stop_q; ENA=0 when CNT==stop_q. This is a combinational compare on CNT, so the counter halts exactly at stop_q.
  - When CNT==stop_q: go to FIN.
- FIN (1 cycle):
  - ENA=0, LOAD=0, DONEowner=1, GNTowner=1.
  - last=owner; go to IDLE.
- GNTx is high in LDC, RUN and FIN for the owner only. GNT0 and GNT1 are never high together.
- Latency:
  - REQ first high in IDLE at edge k: LOAD/GNT high during cycle k..k+1.
  - RUN begins at edge k+1.
  - N = (stop-start) mod 2^WIDTH increments take N cycles in RUN, plus 1 compare cycle, then FIN.
  - DONE is asserted N+2 cycles after GNT rises.
- Wrap-around:
  - stop < start is legal; the counter rolls over 2^WIDTH-1 -> 0 and continues to stop.
  - Example: start 250, stop 3 gives 9 increments.
- start==stop: zero increments; RUN lasts 1 cycle, then FIN.
- Abort: owner REQ deasserted while in LDC or RUN.
  - Next edge: state=IDLE, ENA=0, no DONE pulse.
  - last=owner.
  - Counter retains its value.
- REQ changes of the non-owner while BUSY are ignored. New grants happen only from IDLE, so there is at least one IDLE cycle between jobs.
- START/STOP changes after grant have no effect.

Test Plan:
- Reset then single job: REQ0=1, START0=8'd5, STOP0=8'd9.
  - Required: LOAD=1 for 1 cycle with DATA=5.
  - Required: CNT steps 5..9 and holds at 9.
  - Required: DONE0 pulses once, 6 cycles after GNT0 rises; BUSY returns to 0.
- Wrap: REQ1, START1=8'd250, STOP1=8'd3.
  - Required: CNT 250,251,...,255,0,1,2,3, then ENA=0 and DONE1 pulses.
- Arbitration: REQ0=REQ1=1 held from reset, both with START=0, STOP=2.
  - Required grant order: GNT0, GNT1, GNT0.
  - Required: exactly one IDLE cycle between jobs; never both GNT high.
- start==stop: REQ0, START0=STOP0=8'd10.
  - Required: one LOAD cycle, one RUN cycle with ENA=0, DONE0 pulse; CNT stays 10.
- Abort: REQ0 job START0=0, STOP0=100; drop REQ0 when CNT=20.
  - Required: ENA=0 on the next cycle, no DONE0, GNT0=0, BUSY=0, CNT holds 20 or 21.
  - Required: a subsequent REQ0+REQ1 pair grants requester 1 first.
- Reset mid-RUN: assert RST=1 for 1 cycle while CNT=50 in a 0->100 job.
  - Required: all outputs 0 on the following cycle, no DONE; a fresh job then runs normally.
